// File: rtl/refresh_seq.sv
// rtl/refresh_seq.sv - CAS-before-RAS DRAM refresh sequencer with missed-period accounting
module refresh_seq #(
  parameter int RAS_CYC = 4,
  parameter int PRE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RefReq,
  input  logic       RefUrg,
  input  logic       BACT,
  output logic       nRASref,
  output logic       nCASref,
  output logic       RefBusy,
  output logic       RAMHold,
  output logic       RefDone,
  output logic [2:0] Missed
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_CAS  = 3'd2,
    S_RAS  = 3'd3,
    S_PRE  = 3'd4
  } state_t;

  // The shared down-counter runs from N-1 to 0, so a phase lasts exactly N cycles.
  localparam logic [3:0] RAS_LOAD = 4'(RAS_CYC - 1);
  localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_refreq_q;
  logic       r_ref_done;
  logic [2:0] r_missed;
  logic       w_leave_pre;
  logic       w_period_end;
  logic       w_not_started;

  // A period boundary is the falling edge of RefReq as seen in the CLK domain.
  assign w_period_end  = r_refreq_q & ~RefReq;
  assign w_not_started = (r_state == S_IDLE) || (r_state == S_HOLD);

  // Next-state and counter reload; once CAS is entered the sequence runs to the end.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_leave_pre = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (RefReq && !r_ref_done) begin
          if (!BACT) begin
            w_state_nxt = S_CAS;
          end else if (RefUrg) begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!BACT) begin
          w_state_nxt = S_CAS;
        end
      end
      S_CAS: begin
        w_state_nxt = S_RAS;
        w_cnt_nxt   = RAS_LOAD;
      end
      S_RAS: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_PRE;
          w_cnt_nxt   = PRE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_PRE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
          w_leave_pre = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, counter and RefReq history registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_refreq_q <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_refreq_q <= RefReq;
    end
  end

  // RefDone: set on leaving PRE, cleared whenever RefReq is low (clear has priority).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ref_done <= 1'b0;
    end else if (!RefReq) begin
      r_ref_done <= 1'b0;
    end else if (w_leave_pre) begin
      r_ref_done <= 1'b1;
    end
  end

  // Missed: a period ending with no refresh done or under way bumps a saturating count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_missed <= 3'd0;
    end else if (w_period_end && !r_ref_done && w_not_started && (r_missed != 3'd7)) begin
      r_missed <= r_missed + 3'd1;
    end
  end

  // Strobes are decoded from the state register so reset forces them high asynchronously.
  assign nCASref = ~((r_state == S_CAS) || (r_state == S_RAS));
  assign nRASref = ~(r_state == S_RAS);
  assign RefBusy = (r_state == S_CAS) || (r_state == S_RAS) || (r_state == S_PRE);
  assign RAMHold = RefBusy || (r_state == S_HOLD);
  assign RefDone = r_ref_done;
  assign Missed  = r_missed;

endmodule

// File: tb/tb_refresh_seq.sv
// tb/tb_refresh_seq.sv - vector and scoreboard bench for refresh_seq
module tb_refresh_seq;

  logic       CLK;
  logic       RST;
  logic       RefReq;
  logic       RefUrg;
  logic       BACT;
  logic       nRASref;
  logic       nCASref;
  logic       RefBusy;
  logic       RAMHold;
  logic       RefDone;
  logic [2:0] Missed;

  refresh_seq dut (
    .CLK    (CLK),
    .RST    (RST),
    .RefReq (RefReq),
    .RefUrg (RefUrg),
    .BACT   (BACT),
    .nRASref(nRASref),
    .nCASref(nCASref),
    .RefBusy(RefBusy),
    .RAMHold(RAMHold),
    .RefDone(RefDone),
    .Missed (Missed)
  );

  // Phase codes: {nRASref, nCASref, RefBusy, RAMHold}
  localparam logic [3:0] P_IDLE = 4'b1100;
  localparam logic [3:0] P_HOLD = 4'b1101;
  localparam logic [3:0] P_CAS  = 4'b1011;
  localparam logic [3:0] P_RAS  = 4'b0011;
  localparam logic [3:0] P_PRE  = 4'b1111;

  typedef struct packed {
    logic       req;
    logic       urg;
    logic       bact;
    logic [3:0] ph;
    logic       done;
    logic [2:0] m;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         vec_idx = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] obs();
    return {nRASref, nCASref, RefBusy, RAMHold, RefDone, Missed};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {ras,cas,busy,hold,done,missed}=%b want %b", name, act, exp);
    end
  endtask

  task automatic add(input logic req, input logic urg, input logic bact,
                     input logic [3:0] ph, input logic done, input logic [2:0] m);
    vec_t v;
    v.req = req; v.urg = urg; v.bact = bact; v.ph = ph; v.done = done; v.m = m;
    tbl.push_back(v);
  endtask

  // Trigger from IDLE or HOLD with BACT low, then CAS, 4x RAS, 2x PRE, IDLE with RefDone set.
  task automatic add_refresh(input logic [2:0] m);
    add(1, 0, 0, P_CAS, 0, m);
    for (int i = 0; i < 4; i++) add(1, 0, 0, P_RAS, 0, m);
    for (int i = 0; i < 2; i++) add(1, 0, 0, P_PRE, 0, m);
    add(1, 0, 0, P_IDLE, 1, m);
  endtask

  // Drive each vector at a falling edge, push its expectation, compare at the next falling edge.
  task automatic run_tbl();
    vec_t       v;
    logic [7:0] e;
    while (tbl.size() > 0) begin
      v = tbl.pop_front();
      RefReq = v.req;
      RefUrg = v.urg;
      BACT   = v.bact;
      sb.push_back({v.ph, v.done, v.m});
      @(posedge CLK);
      @(negedge CLK);
      e = sb.pop_front();
      check($sformatf("vec[%0d]", vec_idx), obs(), e);
      vec_idx++;
    end
  endtask

  initial begin
    RST = 1'b1; RefReq = 1'b0; RefUrg = 1'b0; BACT = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_state", obs(), {P_IDLE, 1'b0, 3'd0});
    RST = 1'b0;

    // Opportunistic refresh, then eight missed periods with BACT held, then an urgent HOLD.
    add(0, 0, 0, P_IDLE, 0, 0);
    add_refresh(0);
    add(1, 0, 0, P_IDLE, 1, 0);
    add(0, 0, 0, P_IDLE, 0, 0);
    for (int p = 1; p <= 8; p++) begin
      add(1, 0, 1, P_IDLE, 0, 3'((p - 1 > 7) ? 7 : p - 1));
      add(0, 0, 1, P_IDLE, 0, 3'((p > 7) ? 7 : p));
    end
    add(1, 0, 1, P_IDLE, 0, 7);
    add(1, 1, 1, P_HOLD, 0, 7);
    add(1, 0, 1, P_HOLD, 0, 7);
    add(1, 0, 1, P_HOLD, 0, 7);
    add_refresh(7);
    add(1, 0, 1, P_IDLE, 1, 7);
    add(0, 0, 0, P_IDLE, 0, 7);
    add(1, 0, 0, P_CAS, 0, 7);
    add(1, 0, 0, P_RAS, 0, 7);
    add(1, 0, 0, P_RAS, 0, 7);
    run_tbl();

    // Asynchronous reset in the middle of RAS.
    #2 RST = 1'b1;
    #1 check("async_reset", obs(), {P_IDLE, 1'b0, 3'd0});
    @(negedge CLK);
    check("held_reset", obs(), {P_IDLE, 1'b0, 3'd0});
    RST = 1'b0;
    add_refresh(0);
    run_tbl();

    // RefReq falls during RAS: completes, no miss, RefDone stays low, restarts on RefReq high.
    add(0, 0, 0, P_IDLE, 0, 0);
    add(1, 0, 0, P_CAS, 0, 0);
    add(1, 0, 0, P_RAS, 0, 0);
    add(0, 0, 0, P_RAS, 0, 0);
    add(0, 0, 0, P_RAS, 0, 0);
    add(0, 0, 0, P_RAS, 0, 0);
    add(0, 0, 0, P_PRE, 0, 0);
    add(0, 0, 0, P_PRE, 0, 0);
    add(0, 0, 0, P_IDLE, 0, 0);
    add_refresh(0);

    // HOLD spanning a period end: counts a miss, continues, and refreshes for the new period.
    add(0, 0, 0, P_IDLE, 0, 0);
    add(1, 1, 1, P_HOLD, 0, 0);
    add(0, 0, 1, P_HOLD, 0, 1);
    add(0, 0, 1, P_HOLD, 0, 1);
    add_refresh(1);
    add(1, 0, 0, P_IDLE, 1, 1);
    run_tbl();

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
